alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit 2-bit-opcode ALU.
- Adds configurable data width, an 8-operation opcode set, zero/overflow flags alongside carry, and valid/ready handshakes on both sides with full backpressure.
- Adds a completed-operation counter.
- Sits between the stimulus/driver side and any result consumer; drop-in for ALU datapaths needing throughput of one op per clock.

---
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers operands, S2 registers result and flags and drives the outputs.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic [CNT_W-1:0] ops_done
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    logic             s2_load;
    logic             s1_load;

    logic [WIDTH:0]   wide;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_c;
    logic             nxt_v;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = !rst && s1_load;

    // The extra bit of 'wide' catches the carry, borrow or shifted-out bit.
    always_comb begin
        sh      = s1_b[SH_W-1:0];
        wide    = '0;
        nxt_res = '0;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        unique case (s1_op)
            OP_ADD: begin
                wide    = {1'b0, s1_a} + {1'b0, s1_b};
                nxt_res = wide[WIDTH-1:0];
                nxt_c   = wide[WIDTH];
                nxt_v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                          (nxt_res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, s1_a} - {1'b0, s1_b};
                nxt_res = wide[WIDTH-1:0];
                nxt_c   = wide[WIDTH];
                nxt_v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                          (nxt_res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND: nxt_res = s1_a & s1_b;
            OP_OR:  nxt_res = s1_a | s1_b;
            OP_XOR: nxt_res = s1_a ^ s1_b;
            OP_SHL: begin
                wide    = {1'b0, s1_a} << sh;
                nxt_res = wide[WIDTH-1:0];
                nxt_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {s1_a, 1'b0} >> sh;
                nxt_res = wide[WIDTH:1];
                nxt_c   = wide[0];
            end
            OP_SLT: begin
                nxt_res = {{(WIDTH-1){1'b0}},
                           $signed(s1_a) < $signed(s1_b)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_ADD;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    result    <= nxt_res;
                    carry_out <= nxt_c;
                    zero      <= (nxt_res == '0);
                    overflow  <= nxt_v;
                end
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= a;
                    s1_b  <= b;
                    s1_op <= op_e'(op_code);
                end
            end
            if (out_valid && out_ready)
                ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure,
// reset mid-flight and a randomized stream against a reference model.
module tb_alu_pipe;

    localparam int W = 8;
    localparam int C = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op_code;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         overflow;
    logic [C-1:0] ops_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    exp_t q[$];

    alu_pipe #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op_code(op_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .carry_out(carry_out),
        .zero(zero),
        .overflow(overflow),
        .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed with plain integer arithmetic on 8-bit values.
    function automatic exp_t model(input int x, input int y, input int op);
        exp_t e;
        int   sx;
        int   sy;
        int   s;
        int   sh;
        int   r;
        sx  = (x >= 128) ? x - 256 : x;
        sy  = (y >= 128) ? y - 256 : y;
        sh  = y % 8;
        r   = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            0: begin
                r   = (x + y) % 256;
                e.c = (x + y) > 255;
                s   = sx + sy;
                e.v = (s > 127) || (s < -128);
            end
            1: begin
                r   = (x - y + 256) % 256;
                e.c = x < y;
                s   = sx - sy;
                e.v = (s > 127) || (s < -128);
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin
                r   = (x * (1 << sh)) % 256;
                e.c = (sh != 0) ? ((x / (1 << (8 - sh))) % 2) != 0 : 1'b0;
            end
            6: begin
                r   = x / (1 << sh);
                e.c = (sh != 0) ? ((x / (1 << (sh - 1))) % 2) != 0 : 1'b0;
            end
            default: r = (sx < sy) ? 1 : 0;
        endcase
        e.r = r[W-1:0];
        e.z = (r == 0);
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'h11;
        b        = 8'h22;
        op_code  = 3'd0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, result, carry_out, zero, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%h c=%b z=%b o=%b want 0",
                     out_valid, result, carry_out, zero, overflow);
        end
        checks++;
        if (ops_done !== '0) begin
            errors++;
            $display("FAIL reset_ops_done: got %0d want 0", ops_done);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [2:0] op, input logic [7:0] er,
                          input logic ec, input string name);
        exp_t e;
        e = model(int'(xa), int'(xb), int'(op));
        @(posedge clk); #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = xa;
        b         = xb;
        op_code   = op;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: out_valid=%b want 0", name, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== er || carry_out !== ec ||
            zero !== e.z || overflow !== e.v) begin
            errors++;
            $display("FAIL %s: got v=%b r=%h c=%b z=%b o=%b want 1 %h %b %b %b",
                     name, out_valid, result, carry_out, zero, overflow,
                     er, ec, e.z, e.v);
        end
    endtask

    task automatic test_vectors();
        run_op(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, "add_ff_01");
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ops_done !== 16'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_handshake: ops_done=%0d vld=%b want 1 0",
                     ops_done, out_valid);
        end
        run_op(8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, "sub_80_01");
        run_op(8'h01, 8'h02, 3'd1, 8'hFF, 1'b1, "sub_01_02");
        run_op(8'h81, 8'h01, 3'd5, 8'h02, 1'b1, "shl_81_01");
        run_op(8'h81, 8'h03, 3'd6, 8'h10, 1'b0, "shr_81_03");
        run_op(8'h81, 8'h00, 3'd5, 8'h81, 1'b0, "shl_81_00");
        run_op(8'hFF, 8'h01, 3'd7, 8'h01, 1'b0, "slt_ff_01");
        run_op(8'h01, 8'hFF, 3'd7, 8'h00, 1'b0, "slt_01_ff");
        run_op(8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, "and_f0_3c");
        run_op(8'hF0, 8'h0F, 3'd4, 8'hFF, 1'b0, "xor_f0_0f");
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        int got;
        int first;
        int last;
        do_reset();
        acc       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'd1;
        b         = 8'd1;
        op_code   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            a = 8'(acc + 1);
            b = 8'(acc + 1);
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d want 2", acc);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got   = 0;
        first = -1;
        last  = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                checks++;
                if (got > 2 || result !== 8'(2 * (got + 1))) begin
                    errors++;
                    $display("FAIL bp_out%0d: got %h want %h",
                             got, result, 8'(2 * (got + 1)));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acc >= 3) in_valid = 1'b0;
        end
        checks++;
        if (got != 3 || last - first != 2) begin
            errors++;
            $display("FAIL bp_drain: got %0d beats over %0d cycles want 3 over 2",
                     got, last - first);
        end
        @(negedge clk);
        checks++;
        if (ops_done !== 16'd3) begin
            errors++;
            $display("FAIL bp_ops_done: got %0d want 3", ops_done);
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'd5;
        b         = 8'd6;
        op_code   = 3'd0;
        @(posedge clk); #1;
        a = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ops_done !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_state: got vld=%b done=%0d rdy=%b want 0 0 1",
                     out_valid, ops_done, in_ready);
        end
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mid_rst_stale: got %0d stale beats want 0", stale);
        end
    endtask

    task automatic scoreboard_cycle(inout int exp_done, inout logic pstall,
                                    inout logic [W-1:0] pr,
                                    inout logic [2:0] pf);
        exp_t e;
        @(negedge clk);
        checks++;
        if (ops_done !== 16'(exp_done)) begin
            errors++;
            $display("FAIL rnd_ops_done: got %0d want %0d", ops_done, exp_done);
        end
        if (pstall) begin
            checks++;
            if (out_valid !== 1'b1 || result !== pr ||
                {carry_out, zero, overflow} !== pf) begin
                errors++;
                $display("FAIL rnd_stable: got v=%b r=%h f=%b want 1 %h %b",
                         out_valid, result, {carry_out, zero, overflow}, pr, pf);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rnd_spurious: got r=%h want no beat", result);
            end else begin
                e = q.pop_front();
                if (result !== e.r || carry_out !== e.c ||
                    zero !== e.z || overflow !== e.v) begin
                    errors++;
                    $display("FAIL rnd_beat: got %h %b%b%b want %h %b%b%b",
                             result, carry_out, zero, overflow,
                             e.r, e.c, e.z, e.v);
                end
            end
            exp_done++;
        end
        if (in_valid && in_ready) begin
            q.push_back(model(int'(a), int'(b), int'(op_code)));
            checks++;
            if (q.size() > 2) begin
                errors++;
                $display("FAIL rnd_buffer: got %0d in flight want <=2", q.size());
            end
        end
        pstall = out_valid && !out_ready;
        pr     = result;
        pf     = {carry_out, zero, overflow};
    endtask

    task automatic test_random();
        int         exp_done;
        logic       pstall;
        logic [W-1:0] pr;
        logic [2:0] pf;
        do_reset();
        q.delete();
        exp_done = 0;
        pstall   = 1'b0;
        pr       = '0;
        pf       = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a         = 8'($urandom);
            b         = 8'($urandom);
            op_code   = 3'($urandom);
            scoreboard_cycle(exp_done, pstall, pr, pf);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            scoreboard_cycle(exp_done, pstall, pr, pf);
            @(posedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got %0d beats left want 0", q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op_code   = '0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
